// File: rtl/data_mem_lsu.sv
// Little-endian data memory with a RISC-V load/store front end, a valid/ready request
// handshake, a configurable read-latency pipeline and misaligned/illegal access flagging.
module data_mem_lsu #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned MEM_ADDR_BITS = 17,
  parameter int unsigned READ_LATENCY  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic                     i_we,
  input  logic [2:0]               i_funct3,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [31:0]              i_write_data,
  output logic                     o_resp_valid,
  output logic [31:0]              o_read_data,
  output logic                     o_err
);

  localparam int unsigned DEPTH  = 2 ** (MEM_ADDR_BITS - 2);
  localparam int unsigned STAGES = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
  localparam logic [1:0]  WAIT_CYCLES = 2'(READ_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      r_state, w_state_next;
  logic [1:0]  r_cnt, w_cnt_next;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem   [DEPTH];
  logic [31:0] r_stage [STAGES];

  logic [MEM_ADDR_BITS-3:0] w_idx;
  logic [1:0]               w_lane;
  logic [31:0]              w_rd_word;
  logic [7:0]               w_byte;
  logic [15:0]              w_half;
  logic [31:0]              w_load_ext;
  logic [3:0]               w_be;
  logic [31:0]              w_wdata;
  logic                     w_err;
  logic                     w_accept;
  logic                     w_load_ok;
  logic                     w_wait_done;

  assign w_idx  = i_address[MEM_ADDR_BITS-1:2];
  assign w_lane = i_address[1:0];

  // Upper address bits alias onto the decoded range.
  if (ADDRESS_WIDTH > MEM_ADDR_BITS) begin : g_alias
    logic w_unused_addr;
    assign w_unused_addr = ^i_address[ADDRESS_WIDTH-1:MEM_ADDR_BITS];
  end

  always_comb begin
    w_err = 1'b1;
    case (i_funct3)
      3'b000:          w_err = 1'b0;
      3'b001:          w_err = i_address[0];
      3'b010:          w_err = |w_lane;
      3'b100, 3'b101:  w_err = i_we;
      default:         w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_rd_word  = r_mem[w_idx];
    w_byte     = w_rd_word[{w_lane, 3'b000} +: 8];
    w_half     = i_address[1] ? w_rd_word[31:16] : w_rd_word[15:0];
    w_load_ext = '0;
    case (i_funct3)
      3'b000:  w_load_ext = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_ext = {{16{w_half[15]}}, w_half};
      3'b010:  w_load_ext = w_rd_word;
      3'b100:  w_load_ext = {24'h0, w_byte};
      3'b101:  w_load_ext = {16'h0, w_half};
      default: w_load_ext = '0;
    endcase
  end

  // Sub-word store data is replicated across lanes; the byte enables pick the target lanes.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = i_write_data;
    case (i_funct3)
      3'b000: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{i_write_data[7:0]}};
      end
      3'b001: begin
        w_be    = i_address[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{i_write_data[15:0]}};
      end
      3'b010:  w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign o_req_ready  = !i_rst && (r_state != StWait);
  assign o_resp_valid = !i_rst && (r_state == StResp);
  assign o_err        = !i_rst && r_err;
  assign o_read_data  = i_rst ? 32'h0 : r_rdata;

  assign w_accept    = i_req_valid && o_req_ready;
  assign w_load_ok   = w_accept && !i_we && !w_err;
  assign w_wait_done = (r_state == StWait) && (r_cnt == 2'd1);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      StWait: begin
        if (r_cnt == 2'd1) begin
          w_state_next = StResp;
          w_cnt_next   = 2'd0;
        end else begin
          w_cnt_next = r_cnt - 2'd1;
        end
      end
      StIdle, StResp: begin
        if (w_accept) begin
          if (w_load_ok && (READ_LATENCY > 1)) begin
            w_state_next = StWait;
            w_cnt_next   = WAIT_CYCLES;
          end else begin
            w_state_next = StResp;
          end
        end else begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_cnt   <= 2'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Response data/err only change on the edge that starts a response cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdata <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_wait_done) begin
      r_rdata <= r_stage[STAGES-1];
      r_err   <= 1'b0;
    end else if (w_accept) begin
      if (w_err) begin
        r_rdata <= 32'h0;
        r_err   <= 1'b1;
      end else if (i_we) begin
        r_err <= 1'b0;
      end else if (READ_LATENCY == 1) begin
        r_rdata <= w_load_ext;
        r_err   <= 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_load_ok) begin
      r_stage[0] <= w_load_ext;
    end
    for (int i = 1; i < int'(STAGES); i++) begin
      r_stage[i] <= r_stage[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_accept && i_we && !w_err) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu: one instance with READ_LATENCY=1 and one with 3.
module tb_data_mem_lsu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_req_valid, a_req_ready, a_we, a_resp_valid, a_err;
  logic [2:0]  a_funct3;
  logic [31:0] a_address, a_write_data, a_read_data;

  logic        b_rst, b_req_valid, b_req_ready, b_we, b_resp_valid, b_err;
  logic [2:0]  b_funct3;
  logic [31:0] b_address, b_write_data, b_read_data;

  int n_pass  = 0;
  int n_total = 0;

  data_mem_lsu #(.ADDRESS_WIDTH(32), .MEM_ADDR_BITS(17), .READ_LATENCY(1)) u_dut_l1 (
    .i_clk        (clk),
    .i_rst        (a_rst),
    .i_req_valid  (a_req_valid),
    .o_req_ready  (a_req_ready),
    .i_we         (a_we),
    .i_funct3     (a_funct3),
    .i_address    (a_address),
    .i_write_data (a_write_data),
    .o_resp_valid (a_resp_valid),
    .o_read_data  (a_read_data),
    .o_err        (a_err)
  );

  data_mem_lsu #(.ADDRESS_WIDTH(32), .MEM_ADDR_BITS(17), .READ_LATENCY(3)) u_dut_l3 (
    .i_clk        (clk),
    .i_rst        (b_rst),
    .i_req_valid  (b_req_valid),
    .o_req_ready  (b_req_ready),
    .i_we         (b_we),
    .i_funct3     (b_funct3),
    .i_address    (b_address),
    .i_write_data (b_write_data),
    .o_resp_valid (b_resp_valid),
    .o_read_data  (b_read_data),
    .o_err        (b_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    a_req_valid  = 1'b1;
    a_we         = we;
    a_funct3     = f3;
    a_address    = addr;
    a_write_data = wd;
    tick();
    a_req_valid  = 1'b0;
  endtask

  task automatic b_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    b_req_valid  = 1'b1;
    b_we         = we;
    b_funct3     = f3;
    b_address    = addr;
    b_write_data = wd;
    tick();
    b_req_valid  = 1'b0;
  endtask

  // Checks a response on the L=1 instance in the cycle right after acceptance.
  task automatic a_resp(input string tag, input logic [31:0] data, input logic err);
    check({tag, " valid"}, a_resp_valid, 1);
    check({tag, " data"}, a_read_data, data);
    check({tag, " err"}, a_err, err);
  endtask

  initial begin
    a_rst = 1'b1; a_req_valid = 1'b0; a_we = 1'b0; a_funct3 = 3'b0;
    a_address = '0; a_write_data = '0;
    b_rst = 1'b1; b_req_valid = 1'b0; b_we = 1'b0; b_funct3 = 3'b0;
    b_address = '0; b_write_data = '0;

    tick();
    check("rst ready", a_req_ready, 0);
    check("rst resp_valid", a_resp_valid, 0);
    check("rst err", a_err, 0);
    check("rst data", a_read_data, 32'h0);
    check("rst ready L3", b_req_ready, 0);
    a_rst = 1'b0;
    b_rst = 1'b0;
    tick();
    check("post-rst ready", a_req_ready, 1);
    check("post-rst resp_valid", a_resp_valid, 0);
    check("post-rst ready L3", b_req_ready, 1);

    // L=1: word store then loads, back-to-back from the response state.
    a_req(1'b1, 3'b010, 32'h100, 32'h8040_C0FF);
    a_resp("sw 0x100", 32'h0, 1'b0);
    a_req(1'b0, 3'b010, 32'h100, 32'h0);
    a_resp("lw 0x100", 32'h8040_C0FF, 1'b0);
    a_req(1'b0, 3'b000, 32'h100, 32'h0);
    a_resp("lb 0x100", 32'hFFFF_FFFF, 1'b0);
    a_req(1'b0, 3'b100, 32'h100, 32'h0);
    a_resp("lbu 0x100", 32'h0000_00FF, 1'b0);
    a_req(1'b0, 3'b000, 32'h103, 32'h0);
    a_resp("lb 0x103", 32'hFFFF_FF80, 1'b0);
    a_req(1'b0, 3'b001, 32'h102, 32'h0);
    a_resp("lh 0x102", 32'hFFFF_8040, 1'b0);
    a_req(1'b0, 3'b101, 32'h102, 32'h0);
    a_resp("lhu 0x102", 32'h0000_8040, 1'b0);

    // Byte and half stores merged into a zeroed word.
    a_req(1'b1, 3'b010, 32'h200, 32'h0);
    a_req(1'b1, 3'b000, 32'h201, 32'h1234_56AA);
    a_req(1'b1, 3'b001, 32'h202, 32'hFFFF_1234);
    a_req(1'b0, 3'b010, 32'h200, 32'h0);
    a_resp("lw 0x200 merged", 32'h1234_AA00, 1'b0);

    // Error accesses.
    a_req(1'b0, 3'b001, 32'h101, 32'h0);
    a_resp("lh 0x101 misaligned", 32'h0, 1'b1);
    tick();
    check("idle after err resp_valid", a_resp_valid, 0);
    check("idle ready", a_req_ready, 1);
    a_req(1'b1, 3'b010, 32'h102, 32'hDEAD_BEEF);
    a_resp("sw 0x102 misaligned", 32'h0, 1'b1);
    a_req(1'b0, 3'b010, 32'h100, 32'h0);
    a_resp("lw 0x100 after bad sw", 32'h8040_C0FF, 1'b0);
    a_req(1'b0, 3'b111, 32'h100, 32'h0);
    a_resp("funct3 111", 32'h0, 1'b1);
    a_req(1'b1, 3'b100, 32'h100, 32'h0);
    a_resp("store funct3 100", 32'h0, 1'b1);
    a_req(1'b0, 3'b010, 32'h100, 32'h0);
    a_resp("lw 0x100 after bad sbu", 32'h8040_C0FF, 1'b0);

    // Store response keeps ReadData; read-after-write; address aliasing.
    a_req(1'b1, 3'b010, 32'h300, 32'h1122_3344);
    a_resp("sw 0x300 holds data", 32'h8040_C0FF, 1'b0);
    a_req(1'b0, 3'b010, 32'h300, 32'h0);
    a_resp("lw 0x300 raw", 32'h1122_3344, 1'b0);
    a_req(1'b0, 3'b010, 32'h0002_0100, 32'h0);
    a_resp("lw alias 0x20100", 32'h8040_C0FF, 1'b0);

    // L=3 instance.
    b_req(1'b1, 3'b010, 32'h40, 32'hCAFE_F00D);
    check("L3 sw valid", b_resp_valid, 1);
    check("L3 sw err", b_err, 0);
    b_req(1'b1, 3'b010, 32'h44, 32'h5555_AAAA);
    check("L3 sw2 valid", b_resp_valid, 1);

    b_req_valid = 1'b1; b_we = 1'b0; b_funct3 = 3'b010; b_address = 32'h40;
    tick();
    b_funct3 = 3'b101; b_address = 32'h44;   // held request during the wait
    check("L3 c1 ready", b_req_ready, 0);
    check("L3 c1 valid", b_resp_valid, 0);
    tick();
    check("L3 c2 ready", b_req_ready, 0);
    check("L3 c2 valid", b_resp_valid, 0);
    tick();
    check("L3 c3 valid", b_resp_valid, 1);
    check("L3 c3 data", b_read_data, 32'hCAFE_F00D);
    check("L3 c3 err", b_err, 0);
    check("L3 c3 ready", b_req_ready, 1);
    tick();
    b_req_valid = 1'b0;
    check("L3 c4 ready", b_req_ready, 0);
    check("L3 c4 valid", b_resp_valid, 0);
    check("L3 c4 data held", b_read_data, 32'hCAFE_F00D);
    tick();
    tick();
    check("L3 lhu valid", b_resp_valid, 1);
    check("L3 lhu data", b_read_data, 32'h0000_AAAA);

    b_req(1'b0, 3'b001, 32'h41, 32'h0);
    check("L3 err valid", b_resp_valid, 1);
    check("L3 err flag", b_err, 1);
    check("L3 err data", b_read_data, 32'h0);

    // Reset in WAIT drops the pending response.
    b_req(1'b0, 3'b010, 32'h40, 32'h0);
    check("L3 wait ready", b_req_ready, 0);
    b_rst = 1'b1;
    #1;
    check("L3 rst ready", b_req_ready, 0);
    check("L3 rst valid", b_resp_valid, 0);
    tick();
    b_rst = 1'b0;
    #1;
    check("L3 after rst valid", b_resp_valid, 0);
    tick();
    check("L3 ready two after rst", b_req_ready, 1);
    check("L3 no late resp", b_resp_valid, 0);
    tick();
    check("L3 no late resp 2", b_resp_valid, 0);

    // Memory survives reset.
    b_req(1'b0, 3'b010, 32'h44, 32'h0);
    tick();
    tick();
    check("L3 post-rst lw valid", b_resp_valid, 1);
    check("L3 post-rst lw data", b_read_data, 32'h5555_AAAA);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
